// File: rtl/gng_smul_pipe.sv
// gng_smul_pipe: pipelined signed multiplier with round-half-up rescale,
// overflow flag and saturating overflow counter. Optional: GNG_SMUL_SAT_EN.
module gng_smul_pipe #(
    parameter int A_W   = 16,
    parameter int B_W   = 18,
    parameter int LAT   = 3,
    parameter int SHIFT = 0,
    parameter int OUT_W = 34
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    ce,
    input  logic                    valid_in,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic                    clr_cnt,
    output logic                    valid_out,
    output logic signed [OUT_W-1:0] p,
    output logic                    ovf,
    output logic [15:0]             ovf_cnt
);

    localparam int PW  = A_W + B_W;
    localparam int RW  = PW + 1;
    localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] RND =
        (SHIFT > 0) ? (RW'(1) << SH1) : '0;
`ifdef GNG_SMUL_SAT_EN
    localparam logic signed [OUT_W-1:0] PMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] PMIN = {1'b1, {(OUT_W-1){1'b0}}};
`endif

    logic signed [A_W-1:0]   a_q;
    logic signed [B_W-1:0]   b_q;
    logic                    v1;
    logic signed [PW-1:0]    prod_c;
    logic signed [PW-1:0]    pre;
    logic                    pre_v;
    logic signed [RW-1:0]    ext;
    logic signed [RW-1:0]    sum;
    logic signed [RW-1:0]    r;
    logic [RW-OUT_W:0]       hi;
    logic                    fits;
    logic signed [OUT_W-1:0] p_n;

    // Stage 1: operand and valid capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q <= '0;
            b_q <= '0;
            v1  <= 1'b0;
        end else if (ce) begin
            a_q <= a;
            b_q <= b;
            v1  <= valid_in;
        end
    end

    assign prod_c = PW'(a_q) * PW'(b_q);

    generate
        if (LAT == 2) begin : g_l2
            assign pre   = prod_c;
            assign pre_v = v1;
        end else begin : g_ln
            logic signed [PW-1:0] pd [LAT-2];
            logic [LAT-3:0]       pv;

            // Stage 2 product register followed by plain delay stages
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < LAT - 2; i++) pd[i] <= '0;
                    pv <= '0;
                end else if (ce) begin
                    pd[0] <= prod_c;
                    pv[0] <= v1;
                    for (int i = 1; i < LAT - 2; i++) begin
                        pd[i] <= pd[i-1];
                        pv[i] <= pv[i-1];
                    end
                end
            end

            assign pre   = pd[LAT-3];
            assign pre_v = pv[LAT-3];
        end
    endgenerate

    // One extra bit keeps the rounding add from wrapping
    assign ext  = {pre[PW-1], pre};
    assign sum  = ext + RND;
    assign r    = sum >>> SHIFT;
    assign hi   = r[RW-1:OUT_W-1];
    assign fits = (&hi) | ~(|hi);

    // Narrowed result: wrap by default, clamp when saturation is built in
    always_comb begin
        p_n = r[OUT_W-1:0];
`ifdef GNG_SMUL_SAT_EN
        if (!fits) p_n = r[RW-1] ? PMIN : PMAX;
`endif
    end

    // Final stage: one-cycle result strobe, p holds while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out <= 1'b0;
            ovf       <= 1'b0;
            p         <= '0;
        end else begin
            valid_out <= ce & pre_v;
            ovf       <= ce & pre_v & ~fits;
            if (ce) p <= p_n;
        end
    end

    // Saturating overflow counter, clear wins over increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_cnt <= '0;
        end else if (clr_cnt) begin
            ovf_cnt <= '0;
        end else if (valid_out && ovf && !(&ovf_cnt)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gng_smul_pipe.sv
// tb_gng_smul_pipe: default build and OUT_W=16/SHIFT=15 build side by side,
// checked against a queue model plus hand-computed vectors.
module tb_gng_smul_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ce = 1'b0;
    logic        valid_in = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [15:0] a = '0;
    logic [17:0] b = '0;

    logic        v0, v1o, o0, o1;
    logic [33:0] p0;
    logic [15:0] p1;
    logic [15:0] c0, c1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gng_smul_pipe u0 (
        .clk(clk), .rstn(rstn), .ce(ce), .valid_in(valid_in),
        .a(a), .b(b), .clr_cnt(clr_cnt),
        .valid_out(v0), .p(p0), .ovf(o0), .ovf_cnt(c0)
    );

    gng_smul_pipe #(.OUT_W(16), .SHIFT(15)) u1 (
        .clk(clk), .rstn(rstn), .ce(ce), .valid_in(valid_in),
        .a(a), .b(b), .clr_cnt(clr_cnt),
        .valid_out(v1o), .p(p1), .ovf(o1), .ovf_cnt(c1)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 50)
                $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: exact product, round half up, range test, wrap or clamp
    function automatic void ref_mul(input logic [15:0] ia, input logic [17:0] ib,
                                    input int sh, input int ow,
                                    output longint rp, output logic rovf);
        longint pr, r, hi, lo;
        pr = longint'($signed(ia)) * longint'($signed(ib));
        if (sh == 0) r = pr;
        else r = (pr + (longint'(1) <<< (sh - 1))) >>> sh;
        hi = (longint'(1) <<< (ow - 1)) - 1;
        lo = -hi - 1;
        rovf = (r > hi) || (r < lo);
`ifdef GNG_SMUL_SAT_EN
        if (rovf) r = (r > hi) ? hi : lo;
`endif
        rp = r;
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [17:0] b;
        int          age;
    } ent_t;

    ent_t        q[$];
    logic        ev = 1'b0;
    logic [33:0] ep0 = '0;
    logic        eo0 = 1'b0;
    logic [15:0] ep1 = '0;
    logic        eo1 = 1'b0;
    logic [15:0] ec0 = '0;
    logic [15:0] ec1 = '0;

    // Model: a sample emerges on its third ce-high edge
    initial begin
        ent_t   e;
        longint rr;
        logic   ro;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                q.delete();
                ev = 0; ep0 = '0; eo0 = 0; ep1 = '0; eo1 = 0;
                ec0 = '0; ec1 = '0;
            end else begin
                if (clr_cnt) ec0 = '0;
                else if (ev && eo0 && ec0 != 16'hFFFF) ec0 = ec0 + 1;
                if (clr_cnt) ec1 = '0;
                else if (ev && eo1 && ec1 != 16'hFFFF) ec1 = ec1 + 1;
                ev = 0; eo0 = 0; eo1 = 0;
                if (ce) begin
                    foreach (q[i]) q[i].age++;
                    if (valid_in) q.push_back('{a: a, b: b, age: 1});
                    if (q.size() > 0 && q[0].age == 3) begin
                        e = q.pop_front();
                        ev = 1;
                        ref_mul(e.a, e.b, 0, 34, rr, ro);
                        ep0 = 34'(rr); eo0 = ro;
                        ref_mul(e.a, e.b, 15, 16, rr, ro);
                        ep1 = 16'(rr); eo1 = ro;
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("valid0", v0, ev);
            chk("valid1", v1o, ev);
            chk("ovf0", o0, eo0);
            chk("ovf1", o1, eo1);
            chk("cnt0", c0, ec0);
            chk("cnt1", c1, ec1);
            if (ev) begin
                chk("p0", p0, ep0);
                chk("p1", p1, ep1);
            end
        end
    end

    task automatic issue(input logic [15:0] ia, input logic [17:0] ib,
                         output int k);
        a = ia; b = ib; valid_in = 1; ce = 1;
        k = 0;
        do begin
            @(posedge clk); #1;
            valid_in = 0;
            k++;
        end while (!v0 && k < 10);
    endtask

    initial begin
        int k, n, kf;
        logic [33:0] pf;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_v0", v0, 0);
        chk("rst_p0", p0, 0);
        chk("rst_p1", p1, 0);
        chk("rst_ovf1", o1, 0);
        chk("rst_cnt1", c1, 0);
        rstn = 1;
        @(posedge clk); #1;

        issue(16'd3, 18'h04000, k);
        chk("lat", k, 3);
        chk("p1_3", p1, 16'd2);
        chk("p0_3", p0, 34'd49152);
        chk("ovf1_3", o1, 0);

        issue(16'hFFFD, 18'h04000, k);
        chk("p1_m3", p1, 16'hFFFF);
        chk("p0_m3", p0, 34'h3_FFFF_4000);
        chk("ovf1_m3", o1, 0);

        issue(16'h4000, 18'h10000, k);
`ifdef GNG_SMUL_SAT_EN
        chk("p1_ovf", p1, 16'h7FFF);
`else
        chk("p1_ovf", p1, 16'h8000);
`endif
        chk("ovf1_ovf", o1, 1);
        @(posedge clk); #1;
        chk("cnt1_one", c1, 1);

        issue(16'h7FFF, 18'h1FFFF, k);
        chk("lat_max", k, 3);
        chk("p0_max", p0, 34'h0_FFFD_8001);
        chk("ovf0_max", o0, 0);

        issue(16'h8000, 18'h20000, k);
        chk("p0_min", p0, 34'h1_0000_0000);
        chk("ovf0_min", o0, 0);

        // Stall: one sample, 5 frozen cycles, then resume
        a = 16'd100; b = 18'h3FFF9; valid_in = 1; ce = 1;
        @(posedge clk); #1;
        valid_in = 0; ce = 0;
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (v0) n++;
        end
        ce = 1;
        kf = 0; pf = '0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (v0) begin
                n++;
                if (kf == 0) begin kf = i; pf = p0; end
            end
        end
        chk("stall_pulses", n, 1);
        chk("stall_pos", kf, 2);
        chk("stall_p", pf, 34'h3_FFFF_FD44);

        // Mixed stalls and gaps, overflows straddling stalls
        for (int i = 0; i < 30; i++) begin
            ce = (i % 4 != 2);
            valid_in = (i % 3 != 2);
            a = (i % 2 == 1) ? 16'h4000 : 16'(i * 37);
            b = (i % 2 == 1) ? 18'h10000 : 18'(i * 5 - 40);
            @(posedge clk); #1;
        end
        valid_in = 0; ce = 1;
        repeat (6) @(posedge clk);
        #1;

        // Counter saturation
        clr_cnt = 1;
        @(posedge clk); #1;
        clr_cnt = 0;
        a = 16'h4000; b = 18'h10000; valid_in = 1;
        repeat (65540) @(posedge clk);
        #1;
        valid_in = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("cnt_sat", c1, 16'hFFFF);
        issue(16'h4000, 18'h10000, k);
        repeat (2) @(posedge clk);
        #1;
        chk("cnt_sat2", c1, 16'hFFFF);

        // Clear coinciding with an overflow result
        issue(16'h4000, 18'h10000, k);
        chk("clr_ovf_seen", o1, 1);
        clr_cnt = 1;
        @(posedge clk); #1;
        clr_cnt = 0;
        chk("cnt_clr", c1, 0);

        // Reset with four samples in flight
        ce = 1; valid_in = 1;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 16'h4000 : 16'(i + 5);
            b = (i == 0) ? 18'h10000 : 18'(i + 9);
            @(posedge clk); #1;
        end
        valid_in = 0;
        #1 rstn = 0;
        #1;
        chk("mid_v0", v0, 0);
        chk("mid_v1", v1o, 0);
        chk("mid_p0", p0, 0);
        chk("mid_p1", p1, 0);
        chk("mid_ovf1", o1, 0);
        chk("mid_cnt1", c1, 0);
        #1 rstn = 1;
        n = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (v0 || v1o) n++;
        end
        chk("mid_quiet", n, 0);

        issue(16'd3, 18'h04000, k);
        chk("post_lat", k, 3);
        chk("post_p1", p1, 16'd2);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
